// File: rtl/control_unit_if.sv
// Control-unit bus: instruction fetch and memory handshake in, ALU/datapath controls out.
interface control_unit_if;
  logic [31:0] instruction;
  logic        mem_ready;
  logic [3:0]  estado;
  logic [3:0]  alucontrol;
  logic        alusrc;
  logic [11:0] immediate;
  logic        branch;
  logic        regwrite;
  logic        memread;
  logic        memwrite;
  logic        memtoreg;
  logic        irwrite;
  logic        pcwrite;
  logic        illegal;
  logic        mem_timeout;

  modport master (
    input  instruction, mem_ready,
    output estado, alucontrol, alusrc, immediate, branch, regwrite, memread,
           memwrite, memtoreg, irwrite, pcwrite, illegal, mem_timeout
  );

  modport slave (
    output instruction, mem_ready,
    input  estado, alucontrol, alusrc, immediate, branch, regwrite, memread,
           memwrite, memtoreg, irwrite, pcwrite, illegal, mem_timeout
  );
endinterface

// File: rtl/control_unit.sv
// Multicycle control FSM and instruction decoder for add/sub/xor/srl/lw/sw/beq.
// Every output is registered and reflects the state being entered on each edge.
module control_unit #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input logic            clk,
  input logic            rst_n,
  control_unit_if.master bus
);
  localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

  localparam logic [3:0] FETCH    = 4'b0000;
  localparam logic [3:0] DECODE   = 4'b0001;
  localparam logic [3:0] EXEC_R   = 4'b0010;
  localparam logic [3:0] WB_R     = 4'b0011;
  localparam logic [3:0] BR_RES   = 4'b0100;
  localparam logic [3:0] EXEC_MEM = 4'b0101;
  localparam logic [3:0] EXEC_BEQ = 4'b0110;
  localparam logic [3:0] MEM_RD   = 4'b0111;
  localparam logic [3:0] MEM_WR   = 4'b1000;
  localparam logic [3:0] WB_LW    = 4'b1001;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0101;

  logic [3:0]       state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       alucontrol_q, alucontrol_d;
  logic             alusrc_q, alusrc_d;
  logic [11:0]      immediate_q, immediate_d;
  logic             branch_q, branch_d, regwrite_q, regwrite_d;
  logic             memread_q, memread_d, memwrite_q, memwrite_d;
  logic             memtoreg_q, memtoreg_d, irwrite_q, irwrite_d;
  logic             pcwrite_q, pcwrite_d, illegal_q, illegal_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        dec_legal, dec_alusrc;
  logic [3:0]  dec_state, dec_alu;
  logic [11:0] dec_imm;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  // Instruction decode from the latched IR
  always_comb begin
    dec_legal  = 1'b0;
    dec_state  = FETCH;
    dec_alu    = ALU_ADD;
    dec_alusrc = 1'b0;
    dec_imm    = '0;
    case (opcode)
      OP_R: begin
        dec_state = EXEC_R;
        if (funct7 == 7'b0000000 && funct3 == 3'b000) begin
          dec_legal = 1'b1; dec_alu = ALU_ADD;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_legal = 1'b1; dec_alu = ALU_SUB;
        end else if (funct7 == 7'b0000000 && funct3 == 3'b100) begin
          dec_legal = 1'b1; dec_alu = ALU_XOR;
        end else if (funct7 == 7'b0000000 && funct3 == 3'b101) begin
          dec_legal = 1'b1; dec_alu = ALU_SRL;
        end
      end
      OP_LW: begin
        dec_legal = 1'b1; dec_state = EXEC_MEM; dec_alusrc = 1'b1;
        dec_imm   = ir_q[31:20];
      end
      OP_SW: begin
        dec_legal = 1'b1; dec_state = EXEC_MEM; dec_alusrc = 1'b1;
        dec_imm   = {ir_q[31:25], ir_q[11:7]};
      end
      OP_BR: begin
        dec_state  = EXEC_BEQ; dec_alu = ALU_SUB; dec_alusrc = 1'b1;
        dec_imm    = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8]};
        dec_legal  = (funct3 == 3'b000);
      end
      default: ;
    endcase
  end

  // Next state, then registered outputs for the state being entered
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    cnt_d         = '0;
    alucontrol_d  = alucontrol_q;
    alusrc_d      = alusrc_q;
    immediate_d   = immediate_q;
    branch_d      = 1'b0;
    regwrite_d    = 1'b0;
    memread_d     = 1'b0;
    memwrite_d    = 1'b0;
    memtoreg_d    = 1'b0;
    irwrite_d     = 1'b0;
    pcwrite_d     = 1'b0;
    illegal_d     = 1'b0;
    mem_timeout_d = 1'b0;

    case (state_q)
      FETCH: begin
        ir_d    = bus.instruction;
        state_d = DECODE;
      end
      DECODE: begin
        state_d   = dec_legal ? dec_state : FETCH;
        illegal_d = ~dec_legal;
      end
      EXEC_R:   state_d = WB_R;
      WB_R:     state_d = FETCH;
      EXEC_MEM: state_d = ir_q[5] ? MEM_WR : MEM_RD;
      MEM_RD, MEM_WR: begin
        // mem_ready takes priority over the wait limit
        if (bus.mem_ready) begin
          state_d = (state_q == MEM_RD) ? WB_LW : FETCH;
        end else if (cnt_q == CNT_W'(WAIT_LIMIT)) begin
          state_d       = FETCH;
          mem_timeout_d = 1'b1;
        end
      end
      WB_LW:    state_d = FETCH;
      EXEC_BEQ: state_d = BR_RES;
      BR_RES:   state_d = FETCH;
      default:  state_d = FETCH;
    endcase

    case (state_d)
      FETCH, DECODE: begin
        irwrite_d    = (state_d == FETCH);
        pcwrite_d    = (state_d == FETCH);
        alucontrol_d = '0;
        alusrc_d     = 1'b0;
        immediate_d  = '0;
      end
      EXEC_R, EXEC_MEM, EXEC_BEQ: begin
        alucontrol_d = dec_alu;
        alusrc_d     = dec_alusrc;
        immediate_d  = dec_imm;
        branch_d     = (state_d == EXEC_BEQ);
      end
      WB_R:   regwrite_d = 1'b1;
      MEM_RD: memread_d  = 1'b1;
      MEM_WR: memwrite_d = 1'b1;
      WB_LW: begin
        regwrite_d = 1'b1;
        memtoreg_d = 1'b1;
      end
      BR_RES:  branch_d = 1'b1;
      default: ;
    endcase

    if ((state_d == MEM_RD || state_d == MEM_WR) && state_d == state_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      ir_q          <= '0;
      cnt_q         <= '0;
      alucontrol_q  <= '0;
      alusrc_q      <= 1'b0;
      immediate_q   <= '0;
      branch_q      <= 1'b0;
      regwrite_q    <= 1'b0;
      memread_q     <= 1'b0;
      memwrite_q    <= 1'b0;
      memtoreg_q    <= 1'b0;
      irwrite_q     <= 1'b0;
      pcwrite_q     <= 1'b0;
      illegal_q     <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      cnt_q         <= cnt_d;
      alucontrol_q  <= alucontrol_d;
      alusrc_q      <= alusrc_d;
      immediate_q   <= immediate_d;
      branch_q      <= branch_d;
      regwrite_q    <= regwrite_d;
      memread_q     <= memread_d;
      memwrite_q    <= memwrite_d;
      memtoreg_q    <= memtoreg_d;
      irwrite_q     <= irwrite_d;
      pcwrite_q     <= pcwrite_d;
      illegal_q     <= illegal_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign bus.estado      = state_q;
  assign bus.alucontrol  = alucontrol_q;
  assign bus.alusrc      = alusrc_q;
  assign bus.immediate   = immediate_q;
  assign bus.branch      = branch_q;
  assign bus.regwrite    = regwrite_q;
  assign bus.memread     = memread_q;
  assign bus.memwrite    = memwrite_q;
  assign bus.memtoreg    = memtoreg_q;
  assign bus.irwrite     = irwrite_q;
  assign bus.pcwrite     = pcwrite_q;
  assign bus.illegal     = illegal_q;
  assign bus.mem_timeout = mem_timeout_q;
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class cycle by cycle.
module tb_control_unit;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_bad;

  control_unit_if bus ();

  control_unit #(.WAIT_LIMIT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] E_FETCH = 4'd0, E_DECODE = 4'd1, E_EXEC_R = 4'd2, E_WB_R = 4'd3;
  localparam logic [3:0] E_BR_RES = 4'd4, E_EXEC_MEM = 4'd5, E_EXEC_BEQ = 4'd6;
  localparam logic [3:0] E_MEM_RD = 4'd7, E_MEM_WR = 4'd8, E_WB_LW = 4'd9;

  // {branch, regwrite, memread, memwrite, memtoreg, irwrite, pcwrite, illegal, mem_timeout}
  localparam logic [8:0] S_NONE   = 9'h000;
  localparam logic [8:0] S_FETCH  = 9'h00C;
  localparam logic [8:0] S_F_ILL  = 9'h00E;
  localparam logic [8:0] S_F_TO   = 9'h00D;
  localparam logic [8:0] S_WBR    = 9'h080;
  localparam logic [8:0] S_MRD    = 9'h040;
  localparam logic [8:0] S_MWR    = 9'h020;
  localparam logic [8:0] S_WBLW   = 9'h090;
  localparam logic [8:0] S_BR     = 9'h100;

  logic [8:0] strobes;
  assign strobes = {bus.branch, bus.regwrite, bus.memread, bus.memwrite, bus.memtoreg,
                    bus.irwrite, bus.pcwrite, bus.illegal, bus.mem_timeout};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_cycle(input string tag, input logic [3:0] st, input logic [8:0] stb);
    check({tag, ":estado"}, 32'(bus.estado), 32'(st));
    check({tag, ":strobes"}, 32'(strobes), 32'(stb));
  endtask

  task automatic expect_alu(input string tag, input logic [3:0] alu, input logic src,
                            input logic [11:0] imm);
    check({tag, ":alu"}, 32'({bus.alucontrol, bus.alusrc}), 32'({alu, src}));
    check({tag, ":imm"}, 32'(bus.immediate), 32'(imm));
  endtask

  // R-type from FETCH back to FETCH
  task automatic run_r(input string tag, input logic [31:0] instr, input logic [3:0] alu);
    bus.instruction = instr;
    tick(); expect_cycle({tag, ":dec"}, E_DECODE, S_NONE);
    tick(); expect_cycle({tag, ":ex"}, E_EXEC_R, S_NONE);
    expect_alu({tag, ":ex"}, alu, 1'b0, 12'h000);
    tick(); expect_cycle({tag, ":wb"}, E_WB_R, S_WBR);
    expect_alu({tag, ":wb"}, alu, 1'b0, 12'h000);
    tick(); expect_cycle({tag, ":fe"}, E_FETCH, S_FETCH);
  endtask

  // lw/sw; ready_at = MEM cycle (1-based) with mem_ready high, 0 = never
  task automatic run_mem(input string tag, input logic [31:0] instr, input bit is_lw,
                         input int ready_at, input logic [11:0] imm);
    logic [3:0] mst;
    logic [8:0] mstb;
    mst  = is_lw ? E_MEM_RD : E_MEM_WR;
    mstb = is_lw ? S_MRD : S_MWR;
    bus.instruction = instr;
    tick(); expect_cycle({tag, ":dec"}, E_DECODE, S_NONE);
    tick(); expect_cycle({tag, ":ex"}, E_EXEC_MEM, S_NONE);
    expect_alu({tag, ":ex"}, 4'b0010, 1'b1, imm);
    for (int i = 1; i <= 16; i++) begin
      tick(); expect_cycle({tag, ":mem"}, mst, mstb);
      if (i == ready_at) begin
        bus.mem_ready = 1'b1;
        break;
      end
    end
    tick();
    bus.mem_ready = 1'b0;
    if (ready_at == 0) begin
      expect_cycle({tag, ":to"}, E_FETCH, S_F_TO);
    end else if (is_lw) begin
      expect_cycle({tag, ":wblw"}, E_WB_LW, S_WBLW);
      expect_alu({tag, ":wblw"}, 4'b0010, 1'b1, imm);
      tick(); expect_cycle({tag, ":fe"}, E_FETCH, S_FETCH);
    end else begin
      expect_cycle({tag, ":fe"}, E_FETCH, S_FETCH);
    end
  endtask

  task automatic run_beq(input string tag, input logic [31:0] instr, input logic [11:0] imm);
    bus.instruction = instr;
    tick(); expect_cycle({tag, ":dec"}, E_DECODE, S_NONE);
    tick(); expect_cycle({tag, ":ex"}, E_EXEC_BEQ, S_BR);
    expect_alu({tag, ":ex"}, 4'b0110, 1'b1, imm);
    tick(); expect_cycle({tag, ":res"}, E_BR_RES, S_BR);
    expect_alu({tag, ":res"}, 4'b0110, 1'b1, imm);
    tick(); expect_cycle({tag, ":fe"}, E_FETCH, S_FETCH);
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] instr);
    bus.instruction = instr;
    tick(); expect_cycle({tag, ":dec"}, E_DECODE, S_NONE);
    tick(); expect_cycle({tag, ":ill"}, E_FETCH, S_F_ILL);
  endtask

  initial begin
    n_checks        = 0;
    n_bad           = 0;
    rst_n           = 1'b0;
    bus.instruction = 32'h0;
    bus.mem_ready   = 1'b0;
    tick(); tick();
    expect_cycle("reset", E_FETCH, S_NONE);
    expect_alu("reset", 4'b0000, 1'b0, 12'h000);

    rst_n = 1'b1;
    run_r("add", 32'h00208033, 4'b0010);
    run_r("sub", 32'h40208033, 4'b0110);
    run_r("xor", 32'h0020C033, 4'b0011);
    run_r("srl", 32'h0020D033, 4'b0101);
    run_illegal("ill_r", 32'h0000007F);
    run_mem("lw3", 32'h00812083, 1'b1, 3, 12'h008);
    run_mem("sw_to", 32'h0020A423, 1'b0, 0, 12'h008);
    run_mem("lw_lim", 32'h00812083, 1'b1, 16, 12'h008);
    run_mem("sw1", 32'h0020A423, 1'b0, 1, 12'h008);
    run_mem("lw1", 32'hFFC12083, 1'b1, 1, 12'hFFC);
    run_beq("beq", 32'h00208463, 12'h004);
    run_illegal("ill_op", 32'h0000007F);
    run_illegal("ill_mul", 32'h02208033);
    run_illegal("ill_bne", 32'h00209463);

    // reset mid MEM_RD clears everything immediately
    bus.instruction = 32'h00812083;
    tick(); tick(); tick();
    expect_cycle("pre_rst", E_MEM_RD, S_MRD);
    rst_n = 1'b0;
    #1;
    expect_cycle("mid_rst", E_FETCH, S_NONE);
    expect_alu("mid_rst", 4'b0000, 1'b0, 12'h000);
    tick();
    rst_n = 1'b1;
    run_r("add2", 32'h00208033, 4'b0010);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
